// File: rtl/mc_sequencer_pkg.sv
// Shared encodings for the multi-cycle control sequencer: opcodes, FSM states,
// and the pc_sel / wb_sel / trap_cause codes seen by the datapath.
package mc_sequencer_pkg;

  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] OPC_JAL   = 7'b1101111;
  localparam logic [6:0] OPC_JALR  = 7'b1100111;
  localparam logic [6:0] OPC_BR    = 7'b1100011;
  localparam logic [6:0] OPC_LD    = 7'b0000011;
  localparam logic [6:0] OPC_ST    = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_OP    = 7'b0110011;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_TRAP
  } state_t;

  localparam logic [1:0] PC_PLUS4   = 2'b00;
  localparam logic [1:0] PC_IMM     = 2'b01;
  localparam logic [1:0] PC_RS1_IMM = 2'b10;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL  = 2'b01;
  localparam logic [1:0] CAUSE_IMEM_TMO = 2'b10;
  localparam logic [1:0] CAUSE_DMEM_TMO = 2'b11;

  function automatic logic opcode_known(input logic [6:0] op);
    case (op)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BR,
      OPC_LD, OPC_ST, OPC_OPIMM, OPC_OP: opcode_known = 1'b1;
      default:                           opcode_known = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_sequencer_mem_wait_timer.sv
// Wait-cycle counter shared by the fetch and data-memory handshakes; expired
// fires on the wait cycle that would bring the count to all-ones.
module mc_sequencer_mem_wait_timer #(
  parameter int TMO_W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [TMO_W-1:0] LAST_WAIT = {{(TMO_W-1){1'b1}}, 1'b0};

  logic [TMO_W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count_reg <= '0;
    end else if (en) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign expired = en && (count_reg == LAST_WAIT);

endmodule

// File: rtl/mc_sequencer.sv
// FETCH/DECODE/EXEC/MEM/WB control sequencer with memory req/ack handshakes,
// one-cycle PC/regfile write pulses, retire counter and sticky trap.
module mc_sequencer
  import mc_sequencer_pkg::*;
#(
  parameter int INST_W   = 32,
  parameter int OPCODE_W = 7,
  parameter int TMO_W    = 8,
  parameter int CNT_W    = 32
) (
  input  logic                clk,
  input  logic                rst,
  output logic                imem_req,
  input  logic                imem_ack,
  input  logic [INST_W-1:0]   imem_rdata,
  output logic                dmem_req,
  output logic                dmem_we,
  input  logic                dmem_ack,
  input  logic                alu_zero,
  output logic [INST_W-1:0]   inst,
  output logic [OPCODE_W-1:0] opcode,
  output logic                pc_we,
  output logic [1:0]          pc_sel,
  output logic                reg_we,
  output logic [1:0]          wb_sel,
  output logic                alu_src,
  output logic                trap,
  output logic [1:0]          trap_cause,
  output logic [CNT_W-1:0]    retired
);

  state_t            state_reg;
  logic [INST_W-1:0] inst_reg;
  logic [1:0]        cause_reg;
  logic [CNT_W-1:0]  retired_reg;

  logic [6:0] op7;
  logic is_br, is_ld, is_st, is_jal, is_jalr, is_op;
  logic in_fetch, in_mem, wait_acked;
  logic tmr_clr, tmr_en, tmr_expired;

  assign op7     = inst_reg[6:0];
  assign is_br   = (op7 == OPC_BR);
  assign is_ld   = (op7 == OPC_LD);
  assign is_st   = (op7 == OPC_ST);
  assign is_jal  = (op7 == OPC_JAL);
  assign is_jalr = (op7 == OPC_JALR);
  assign is_op   = (op7 == OPC_OP);

  assign in_fetch = (state_reg == ST_FETCH);
  assign in_mem   = (state_reg == ST_MEM);

  // Holding the timer clear outside the wait states, and on the ack that
  // leaves one, means every entry into FETCH or MEM starts from zero.
  assign wait_acked = (in_fetch && imem_ack) || (in_mem && dmem_ack);
  assign tmr_en     = (in_fetch && !imem_ack) || (in_mem && !dmem_ack);
  assign tmr_clr    = !(in_fetch || in_mem) || wait_acked;

  mc_sequencer_mem_wait_timer #(
    .TMO_W (TMO_W)
  ) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (tmr_clr),
    .en      (tmr_en),
    .expired (tmr_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_FETCH;
      inst_reg    <= '0;
      cause_reg   <= CAUSE_NONE;
      retired_reg <= '0;
    end else begin
      case (state_reg)
        ST_FETCH: begin
          if (imem_ack) begin
            inst_reg  <= imem_rdata;
            state_reg <= ST_DECODE;
          end else if (tmr_expired) begin
            cause_reg <= CAUSE_IMEM_TMO;
            state_reg <= ST_TRAP;
          end
        end
        ST_DECODE: begin
          if (opcode_known(op7)) begin
            state_reg <= ST_EXEC;
          end else begin
            cause_reg <= CAUSE_ILLEGAL;
            state_reg <= ST_TRAP;
          end
        end
        ST_EXEC: begin
          if (is_br) begin
            retired_reg <= retired_reg + 1'b1;
            state_reg   <= ST_FETCH;
          end else if (is_ld || is_st) begin
            state_reg <= ST_MEM;
          end else begin
            state_reg <= ST_WB;
          end
        end
        ST_MEM: begin
          if (dmem_ack) begin
            if (is_st) begin
              retired_reg <= retired_reg + 1'b1;
              state_reg   <= ST_FETCH;
            end else begin
              state_reg <= ST_WB;
            end
          end else if (tmr_expired) begin
            cause_reg <= CAUSE_DMEM_TMO;
            state_reg <= ST_TRAP;
          end
        end
        ST_WB: begin
          retired_reg <= retired_reg + 1'b1;
          state_reg   <= ST_FETCH;
        end
        default: begin
          state_reg <= ST_TRAP;
        end
      endcase
    end
  end

  // Requests are masked while rst is held so nothing is issued during reset.
  assign imem_req = !rst && in_fetch;
  assign dmem_req = !rst && in_mem;
  assign dmem_we  = dmem_req && is_st;

  assign pc_we  = ((state_reg == ST_EXEC) && is_br) ||
                  (in_mem && dmem_ack && is_st) ||
                  (state_reg == ST_WB);
  assign reg_we = (state_reg == ST_WB);

  assign alu_src = ((state_reg == ST_EXEC) || in_mem || (state_reg == ST_WB)) &&
                   !(is_op || is_br);

  always_comb begin
    pc_sel = PC_PLUS4;
    wb_sel = WB_ALU;
    case (state_reg)
      ST_EXEC: begin
        if (is_br && alu_zero) pc_sel = PC_IMM;
      end
      ST_WB: begin
        if (is_jal)       pc_sel = PC_IMM;
        else if (is_jalr) pc_sel = PC_RS1_IMM;
        if (is_ld)                  wb_sel = WB_MEM;
        else if (is_jal || is_jalr) wb_sel = WB_PC4;
      end
      default: ;
    endcase
  end

  assign inst       = inst_reg;
  assign opcode     = inst_reg[OPCODE_W-1:0];
  assign trap       = (state_reg == ST_TRAP);
  assign trap_cause = cause_reg;
  assign retired    = retired_reg;

endmodule
